// File: rtl/pc_ras_pkg.sv
// rtl/pc_ras_pkg.sv - PC flow-control op codes shared by the fetch-stage PC logic.
package pc_ras_pkg;

    typedef enum logic [1:0] {
        NORMAL_OP   = 2'b00,
        RST_OP      = 2'b01,
        PAUSE_OP    = 2'b10,
        REDIRECT_OP = 2'b11
    } pc_op_e;

endpackage

// File: rtl/pc_ras_ras_stack.sv
// rtl/pc_ras_ras_stack.sv - circular return-address stack with push, pop and replace.
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_top,
    output logic         o_empty,
    output logic         o_full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_ptr;
    logic [CW-1:0] r_count;
    logic          w_empty;
    logic          w_full;
    logic [PW-1:0] w_ptr_inc;
    logic [PW-1:0] w_ptr_dec;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_ptr_inc = r_ptr + PW'(1);
    assign w_ptr_dec = r_ptr - PW'(1);

    // r_ptr always names the top entry; a push past a full stack silently overwrites the oldest.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (i_push && i_pop) begin
            if (w_empty) begin
                r_count <= CW'(1);
            end
        end else if (i_push) begin
            r_ptr <= w_ptr_inc;
            if (!w_full) begin
                r_count <= r_count + CW'(1);
            end
        end else if (i_pop && !w_empty) begin
            r_ptr   <= w_ptr_dec;
            r_count <= r_count - CW'(1);
        end
    end

    // Storage has no reset; the count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!rst && !i_clear) begin
            if (i_push && i_pop) begin
                r_mem[r_ptr] <= i_data;
            end else if (i_push) begin
                r_mem[w_ptr_inc] <= i_data;
            end
        end
    end

    assign o_top   = r_mem[r_ptr];
    assign o_empty = w_empty;
    assign o_full  = w_full;

endmodule

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - fetch PC register with next-PC selection and return-address prediction.
module pc_ras
    import pc_ras_pkg::*;
#(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
    parameter int                 STEP      = 1,
    parameter int                 RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        pc_op_i,
    input  logic [ADDR_W-1:0] redirect_addr_i,
    input  logic              is_jump_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              is_call_i,
    input  logic              is_ret_i,
    input  logic [ADDR_W-1:0] link_addr_i,
    output logic [ADDR_W-1:0] ins_addr_o,
    output logic [ADDR_W-1:0] pc_plus_one_o,
    output logic              ras_empty_o,
    output logic              ras_full_o,
    output logic              ras_miss_o
);

    logic [ADDR_W-1:0] r_pc;
    logic              r_miss;
    logic [ADDR_W-1:0] w_next_pc;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_ras_top;
    logic              w_ras_empty;
    logic              w_ras_full;
    logic              w_push;
    logic              w_pop;
    logic              w_clear;
    logic              w_miss;

    assign w_pc_inc = r_pc + ADDR_W'(STEP);

    always_comb begin
        w_next_pc = r_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_clear   = 1'b0;
        w_miss    = 1'b0;
        case (pc_op_e'(pc_op_i))
            RST_OP: begin
                w_next_pc = RESET_VEC;
                w_clear   = 1'b1;
            end
            REDIRECT_OP: w_next_pc = redirect_addr_i;
            PAUSE_OP:    w_next_pc = r_pc;
            default: begin
                if (!is_jump_i) begin
                    w_next_pc = w_pc_inc;
                end else begin
                    w_next_pc = jump_addr_i;
                    w_push    = is_call_i;
                    if (is_ret_i) begin
                        w_pop = 1'b1;
                        if (!w_ras_empty) begin
                            w_next_pc = w_ras_top;
                        end else begin
                            w_miss = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= RESET_VEC;
            r_miss <= 1'b0;
        end else begin
            r_pc   <= w_next_pc;
            r_miss <= w_miss;
        end
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (link_addr_i),
        .o_top   (w_ras_top),
        .o_empty (w_ras_empty),
        .o_full  (w_ras_full)
    );

    assign ins_addr_o    = r_pc;
    assign pc_plus_one_o = w_pc_inc;
    assign ras_empty_o   = w_ras_empty;
    assign ras_full_o    = w_ras_full;
    assign ras_miss_o    = r_miss;

endmodule

// File: tb/tb_pc_ras.sv
// tb/tb_pc_ras.sv - directed self-checking bench for pc_ras.
module tb_pc_ras;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  op;
    logic [31:0] redir;
    logic        jmp;
    logic [31:0] jaddr;
    logic        call;
    logic        ret;
    logic [31:0] link;
    logic [31:0] pc;
    logic [31:0] pc1;
    logic        empty;
    logic        full;
    logic        miss;

    logic        b_rst;
    logic [1:0]  b_op;
    logic [7:0]  b_redir;
    logic [7:0]  b_pc;
    logic [7:0]  b_pc1;
    logic        b_empty;
    logic        b_full;
    logic        b_miss;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    pc_ras #(
        .ADDR_W    (32),
        .RESET_VEC (32'h100),
        .STEP      (4),
        .RAS_DEPTH (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_op_i         (op),
        .redirect_addr_i (redir),
        .is_jump_i       (jmp),
        .jump_addr_i     (jaddr),
        .is_call_i       (call),
        .is_ret_i        (ret),
        .link_addr_i     (link),
        .ins_addr_o      (pc),
        .pc_plus_one_o   (pc1),
        .ras_empty_o     (empty),
        .ras_full_o      (full),
        .ras_miss_o      (miss)
    );

    pc_ras #(
        .ADDR_W    (8),
        .RESET_VEC (8'h00),
        .STEP      (1),
        .RAS_DEPTH (2)
    ) dut_w (
        .clk             (clk),
        .rst             (b_rst),
        .pc_op_i         (b_op),
        .redirect_addr_i (b_redir),
        .is_jump_i       (1'b0),
        .jump_addr_i     (8'h00),
        .is_call_i       (1'b0),
        .is_ret_i        (1'b0),
        .link_addr_i     (8'h00),
        .ins_addr_o      (b_pc),
        .pc_plus_one_o   (b_pc1),
        .ras_empty_o     (b_empty),
        .ras_full_o      (b_full),
        .ras_miss_o      (b_miss)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] o, input logic j, input logic c, input logic r,
                         input logic [31:0] ja, input logic [31:0] lk);
        op = o; jmp = j; call = c; ret = r; jaddr = ja; link = lk;
        step();
    endtask

    initial begin
        rst = 1'b1; op = 2'd0; redir = '0; jmp = 0; jaddr = '0; call = 0; ret = 0; link = '0;
        b_rst = 1'b1; b_op = 2'd0; b_redir = '0;
        #1;
        step(); step();
        chk("rst_pc", pc, 32'h100);
        chk("rst_pc1", pc1, 32'h104);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_miss", {31'd0, miss}, 32'd0);
        rst = 1'b0;

        drive(2'd0, 0, 0, 0, 0, 0); chk("seq1", pc, 32'h104); chk("seq1_p1", pc1, 32'h108);
        drive(2'd0, 0, 0, 0, 0, 0); chk("seq2", pc, 32'h108);
        drive(2'd0, 0, 0, 0, 0, 0); chk("seq3", pc, 32'h10C); chk("seq3_p1", pc1, 32'h110);

        drive(2'd0, 1, 1, 0, 32'h40, 32'h11); chk("call_pc", pc, 32'h40);
        chk("call_empty", {31'd0, empty}, 32'd0);
        drive(2'd0, 1, 0, 1, 32'hDEAD, 0); chk("ret_pc", pc, 32'h11);
        chk("ret_empty", {31'd0, empty}, 32'd1);
        chk("ret_miss", {31'd0, miss}, 32'd0);

        drive(2'd0, 1, 0, 0, 32'h300, 32'h55); chk("plain_jmp", pc, 32'h300);
        chk("plain_empty", {31'd0, empty}, 32'd1);
        drive(2'd0, 0, 1, 1, 32'h999, 32'h66); chk("unqual_pc", pc, 32'h304);
        chk("unqual_empty", {31'd0, empty}, 32'd1);
        chk("unqual_miss", {31'd0, miss}, 32'd0);

        for (int i = 1; i <= 5; i++) begin
            drive(2'd0, 1, 1, 0, 32'h400 + i, i);
            chk("ovf_call_pc", pc, 32'h400 + i);
            chk("ovf_full", {31'd0, full}, (i >= 4) ? 32'd1 : 32'd0);
        end
        for (int i = 5; i >= 2; i--) begin
            drive(2'd0, 1, 0, 1, 32'hDEAD, 0);
            chk("ovf_ret_pc", pc, i);
            chk("ovf_ret_miss", {31'd0, miss}, 32'd0);
        end
        chk("ovf_drained", {31'd0, empty}, 32'd1);
        drive(2'd0, 1, 0, 1, 32'hDEAD, 0);
        chk("ovf_miss_pc", pc, 32'hDEAD);
        chk("ovf_miss", {31'd0, miss}, 32'd1);
        drive(2'd0, 0, 0, 0, 0, 0);
        chk("miss_pulse", {31'd0, miss}, 32'd0);
        chk("after_miss_pc", pc, 32'hDEB1);

        drive(2'd0, 1, 1, 0, 32'h50, 32'h77); chk("pri_call", pc, 32'h50);
        drive(2'd2, 1, 1, 0, 32'h999, 32'h88); chk("pause_pc", pc, 32'h50);
        chk("pause_miss", {31'd0, miss}, 32'd0);
        redir = 32'h200;
        drive(2'd3, 1, 1, 0, 32'h999, 32'h99); chk("redir_pc", pc, 32'h200);
        drive(2'd0, 1, 0, 1, 32'hDEAD, 0); chk("pri_ret", pc, 32'h77);
        chk("pri_empty", {31'd0, empty}, 32'd1);
        drive(2'd0, 1, 1, 0, 32'h60, 32'hA);
        drive(2'd0, 1, 1, 0, 32'h64, 32'hB);
        drive(2'd1, 1, 1, 0, 32'h999, 32'hC); chk("rstop_pc", pc, 32'h100);
        chk("rstop_empty", {31'd0, empty}, 32'd1);
        drive(2'd0, 1, 0, 1, 32'h123, 0); chk("rstop_ret", pc, 32'h123);
        chk("rstop_miss", {31'd0, miss}, 32'd1);

        drive(2'd0, 1, 1, 0, 32'h60, 32'h11); chk("tc_call", pc, 32'h60);
        drive(2'd0, 1, 1, 1, 32'h70, 32'h22); chk("tc_pc", pc, 32'h11);
        chk("tc_empty", {31'd0, empty}, 32'd0);
        chk("tc_miss", {31'd0, miss}, 32'd0);
        drive(2'd0, 1, 0, 1, 32'hDEAD, 0); chk("tc_ret", pc, 32'h22);
        chk("tc_ret_empty", {31'd0, empty}, 32'd1);
        drive(2'd0, 1, 1, 1, 32'h80, 32'h33); chk("tc0_pc", pc, 32'h80);
        chk("tc0_miss", {31'd0, miss}, 32'd1);
        chk("tc0_empty", {31'd0, empty}, 32'd0);
        drive(2'd0, 1, 0, 1, 32'hDEAD, 0); chk("tc0_ret", pc, 32'h33);
        chk("tc0_ret_empty", {31'd0, empty}, 32'd1);

        b_rst = 1'b0; b_op = 2'd3; b_redir = 8'hFF;
        step(); chk("wrap_ff", {24'd0, b_pc}, 32'hFF);
        chk("wrap_p1", {24'd0, b_pc1}, 32'h00);
        b_op = 2'd0;
        step(); chk("wrap_00", {24'd0, b_pc}, 32'h00);
        chk("wrap_00_p1", {24'd0, b_pc1}, 32'h01);
        chk("wrap_empty", {31'd0, b_empty}, 32'd1);
        chk("wrap_full", {31'd0, b_full}, 32'd0);
        chk("wrap_miss", {31'd0, b_miss}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/pc_ras.md
Name: pc_ras

Overview:
Parametrised program-counter unit for the IF stage, replacing the fixed 32-bit PC.
- Selects the next fetch address from: sequential step, ID jump target, external redirect, reset vector, or hold.
- Adds an internal return-address stack (RAS) so ID-resolved returns take a predicted target from calls tracked in hardware.
- Drives IF with the fetch address and IF-ID with the sequential successor.

Parameters:
- ADDR_W, 32: width of all address ports and internal PC.
- RESET_VEC, 0: value loaded into the PC on rst and on the RST op.
- STEP, 1: sequential increment; 1 means word-addressed, 4 means byte-addressed.
- RAS_DEPTH, 4: RAS entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- pc_op_i  in  2  flow-control op: 0 NORMAL, 1 RST, 2 PAUSE, 3 REDIRECT.
- redirect_addr_i  in  ADDR_W  target used when pc_op_i is REDIRECT.
- is_jump_i  in  1  ID reports a taken jump.
- jump_addr_i  in  ADDR_W  ID-computed jump target.
- is_call_i  in  1  the jump is a call; qualified by is_jump_i.
- is_ret_i  in  1  the jump is a return; qualified by is_jump_i.
- link_addr_i  in  ADDR_W  return address to push on a call, supplied by ID.
- ins_addr_o  out  ADDR_W  current fetch address (registered).
- pc_plus_one_o  out  ADDR_W  ins_addr_o + STEP (combinational).
- ras_empty_o  out  1  RAS holds no entries.
- ras_full_o  out  1  RAS holds RAS_DEPTH entries.
- ras_miss_o  out  1  registered one-cycle pulse: a return was taken while the RAS was empty.

Behaviour:
Reset (rst high at a clock edge):
- ins_addr_o = RESET_VEC; RAS count = 0; top pointer = 0; ras_miss_o = 0.
- rst overrides every other input.

Next-PC selection, priority high to low:
1. RST op: PC = RESET_VEC; RAS cleared (count 0).
2. REDIRECT op: PC = redirect_addr_i; RAS unchanged; no push or pop.
3. PAUSE op: PC held; RAS held; ras_miss_o = 0.
4. NORMAL op, by jump kind:
   - No jump: PC = ins_addr_o + STEP.
   - Plain jump (call and ret both low): PC = jump_addr_i.
   - Return: PC = RAS top if not empty, else jump_addr_i; pop.
   - Call: PC = jump_addr_i; push link_addr_i.

Qualifiers and boundaries:
- is_call_i and is_ret_i are ignored while is_jump_i is low.
- Arithmetic is modulo 2^ADDR_W; an all-ones PC plus STEP wraps to low values without error.
- Push when full: circular overwrite of the oldest entry; pointer advances; count saturates at RAS_DEPTH.
- Pop when empty: target = jump_addr_i; count stays 0; ras_miss_o = 1 the next cycle.
- Call and ret in the same cycle (tail-call):
  - Target = old top, or jump_addr_i if empty.
  - The top entry is replaced by link_addr_i; count unchanged, except empty goes to 1.
  - ras_miss_o follows the empty rule above.
- ras_miss_o is 0 in every cycle not caused by an empty pop.
- RAS contents are not reset, only the count and pointer; outputs never expose stale entries.

Latency and output timing:
- Single cycle: the op sampled at edge N takes effect in ins_addr_o after edge N.
- Status outputs reflect the registered count.

Decomposition:
- Shared defines file holds the PC op codes (NORMAL_OP, RST_OP, PAUSE_OP, REDIRECT_OP); the existing codes keep their values and REDIRECT_OP = 2'b11 is added.
- One sub-module, ras_stack (parameters DEPTH, W), owns the storage, pointer, count, push/pop/replace and empty/full.
- pc_ras holds the next-PC mux, the PC register and ras_miss_o.

Test Plan:
- Reset and sequential fetch, RESET_VEC=0x100, STEP=4: hold rst for 2 cycles, then NORMAL for 3 cycles -> ins_addr_o = 0x100, 0x104, 0x108, 0x10C; pc_plus_one_o = ins_addr_o + 4.
- Call/return: call jump_addr=0x40, link=0x11, then ret with jump_addr=0xDEAD -> PC = 0x40 then 0x11; ras_empty_o returns to 1; ras_miss_o stays 0.
- Overflow, RAS_DEPTH=4: 5 calls with links 1..5, then 5 returns -> targets 5, 4, 3, 2, then the 5th return takes jump_addr_i with ras_miss_o = 1 for one cycle; ras_full_o high after the 4th call.
- Priority: PAUSE with is_jump_i=1 holds PC and RAS; REDIRECT to 0x200 during a call pushes nothing; RST op mid-stack -> PC = RESET_VEC and ras_empty_o = 1.
- Tail-call: RAS holds [0x11]; call+ret with link=0x22 -> PC = 0x11; count stays 1; the next ret goes to 0x22.
- Wrap, ADDR_W=8, STEP=1: PC = 0xFF with NORMAL -> PC = 0x00, no X values.
